// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stages: operand width, opcodes and
// the handshake state encoding used by the issue stage.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  // 2'b11 is deliberately left unnamed; the issue stage treats it as illegal.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result flags (zero and odd parity), shared by the logic stage
// and the later arithmetic stages.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_y,
  output logic             o_zero,
  output logic             o_par
);

  assign o_zero = (i_y == '0);
  assign o_par  = ^i_y;

endmodule

// File: rtl/alu_logic_issue.sv
// Issue/capture stage around the external 4-bit logic unit: registers an
// operand bundle, waits one cycle for the unit, then holds the result until taken.
module alu_logic_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [1:0]       lu_op,
  input  logic [WIDTH-1:0] lu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_par,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  logic [WIDTH-1:0] r_luA;
  logic [WIDTH-1:0] r_luB;
  logic [1:0]       r_luOp;
  logic [WIDTH-1:0] r_outY;
  logic             r_outZero;
  logic             r_outPar;
  logic [CNT_W-1:0] r_opCount;

  logic w_inReady;
  logic w_accept;
  logic w_consume;
  logic w_zero;
  logic w_par;

  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flags (
    .i_y    (lu_y),
    .o_zero (w_zero),
    .o_par  (w_par)
  );

  // A finishing result can hand its slot straight to the next bundle.
  assign w_inReady = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && w_inReady;
  assign w_consume = (r_state == S_DONE) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_luA     <= '0;
      r_luB     <= '0;
      r_luOp    <= '0;
      r_outY    <= '0;
      r_outZero <= 1'b1;
      r_outPar  <= 1'b0;
      r_opCount <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_luA   <= in_a;
            r_luB   <= in_b;
            r_luOp  <= in_op;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_outY    <= lu_y;
          r_outZero <= w_zero;
          r_outPar  <= w_par;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (w_consume) begin
            r_opCount <= r_opCount + 1'b1;
            if (w_accept) begin
              r_luA   <= in_a;
              r_luB   <= in_b;
              r_luOp  <= in_op;
              r_state <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = (r_state == S_DONE);
  assign lu_a      = r_luA;
  assign lu_b      = r_luB;
  assign lu_op     = r_luOp;
  assign out_y     = r_outY;
  assign out_zero  = r_outZero;
  assign out_par   = r_outPar;
  assign op_count  = r_opCount;

endmodule
